// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, frame width, default line timing.
package uart_pkg;
  localparam int DATA_BITS         = 8;
  localparam int CLK_FREQ_HZ_DEF   = 50_000_000;
  localparam int BAUD_RATE_DEF     = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; 2 clk latency, no backpressure.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre sampling; byte out ~2+HALF+9*CLKS_PER_BIT+1 clks after start edge.
// No backpressure: data_ready is a one-clock pulse and uart_data holds until the next good byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = CLK_FREQ_HZ_DEF,
  parameter int BAUD_RATE    = BAUD_RATE_DEF,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       data_ready,
  output logic       frame_error,
  output logic       busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_q,   state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 ready_q,   ready_d;
  logic                 ferr_q,    ferr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // A start bit that is high again at its centre was only a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d        = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // Hold here until the line recovers so a stuck-low line reports once.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
    end
  end

  assign uart_data   = data_q;
  assign data_ready  = ready_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: frames, glitches, framing errors, reset, break.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2 - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] uart_data;
  logic       data_ready;
  logic       frame_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int cyc          = 0;
  int rdy_cnt      = 0;
  int ferr_cnt     = 0;
  int wide_rdy     = 0;
  int wide_ferr    = 0;
  int both_cnt     = 0;
  int last_rdy_cyc = 0;
  int fall_cyc     = 0;
  logic prev_rdy   = 1'b0;
  logic prev_ferr  = 1'b0;
  logic [7:0] got_q[$];

  int r0;
  int f0;
  int n;
  int lat;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .uart_data   (uart_data),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_ready) begin
      rdy_cnt++;
      last_rdy_cyc = cyc;
      got_q.push_back(uart_data);
    end
    if (frame_error) ferr_cnt++;
    if (data_ready && prev_rdy) wide_rdy++;
    if (frame_error && prev_ferr) wide_ferr++;
    if (data_ready && frame_error) both_cnt++;
    prev_rdy  = data_ready;
    prev_ferr = frame_error;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int k);
    for (int i = 0; i < k; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", uart_data, 8'h00);
    chk("rst_rdy", data_ready, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    idle_bits(1);

    // plain frame, with latency window 154 +/- 1
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'h35, 1'b1);
    idle_bits(1);
    chk("b35_rdy_cnt", rdy_cnt - r0, 1);
    chk("b35_ferr_cnt", ferr_cnt - f0, 0);
    chk("b35_data", uart_data, 8'h35);
    lat = last_rdy_cyc - fall_cyc;
    chk("b35_latency", lat, (lat >= 153 && lat <= 155) ? lat : 154);

    // short low glitch rejected
    r0 = rdy_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    rx = 1'b1;
    n = 0;
    while (busy && n < HALF + 3) begin
      @(negedge clk);
      n++;
    end
    chk("glitch_busy_lo", busy, 0);
    idle_bits(1);
    chk("glitch_rdy_cnt", rdy_cnt - r0, 0);
    chk("glitch_ferr_cnt", ferr_cnt - f0, 0);

    // stop bit low -> framing error, data retained
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    idle_bits(2);
    chk("ferr_cnt", ferr_cnt - f0, 1);
    chk("ferr_rdy_cnt", rdy_cnt - r0, 0);
    chk("ferr_data_kept", uart_data, 8'h35);
    chk("ferr_busy", busy, 0);
    r0 = rdy_cnt;
    send_frame(8'h00, 1'b1);
    idle_bits(1);
    chk("b00_rdy_cnt", rdy_cnt - r0, 1);
    chk("b00_data", uart_data, 8'h00);

    // zero-gap stream
    r0 = rdy_cnt;
    got_q.delete();
    send_frame(8'h31, 1'b1);
    send_frame(8'h30, 1'b1);
    send_frame(8'h39, 1'b1);
    idle_bits(1);
    chk("stream_rdy_cnt", rdy_cnt - r0, 3);
    chk("stream_q_size", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("stream_b0", got_q[0], 8'h31);
      chk("stream_b1", got_q[1], 8'h30);
      chk("stream_b2", got_q[2], 8'h39);
    end

    // reset in the middle of data bit 4 of 0xFF
    r0 = rdy_cnt; f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_data", uart_data, 8'h00);
    chk("rst_mid_rdy", data_ready, 0);
    chk("rst_mid_ferr", frame_error, 0);
    chk("rst_mid_busy", busy, 0);
    reset = 1'b0;
    idle_bits(6);
    chk("rst_mid_rdy_cnt", rdy_cnt - r0, 0);
    chk("rst_mid_ferr_cnt", ferr_cnt - f0, 0);
    r0 = rdy_cnt;
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    chk("b5a_rdy_cnt", rdy_cnt - r0, 1);
    chk("b5a_data", uart_data, 8'h5A);

    // line held low for 40 bit times
    r0 = rdy_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    chk("break_busy", busy, 1);
    idle_bits(2);
    chk("break_ferr_cnt", ferr_cnt - f0, 1);
    chk("break_rdy_cnt", rdy_cnt - r0, 0);
    chk("break_busy_after", busy, 0);
    r0 = rdy_cnt;
    send_frame(8'h7E, 1'b1);
    idle_bits(1);
    chk("b7e_rdy_cnt", rdy_cnt - r0, 1);
    chk("b7e_data", uart_data, 8'h7E);

    chk("rdy_pulse_width", wide_rdy, 0);
    chk("ferr_pulse_width", wide_ferr, 0);
    chk("rdy_ferr_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
